// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues in-order I-cache requests, buffers responses
// and hands {pc, pc+4, instr} to decode; redirects squash buffered and in-flight work.
module if_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 4,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_inc_pc,
   output logic [XLEN-1:0] o_instr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef enum logic {IDLE, FETCH} state_t;
   state_t state, state_nxt;

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   inflight, count, discard;
   logic [CW:0]     occupancy;
   logic [XLEN-1:0] buf_pc    [DEPTH];
   logic [XLEN-1:0] buf_instr [DEPTH];
   logic [XLEN-1:0] tag_q     [DEPTH];
   logic [AW-1:0]   buf_wr, buf_rd, tag_wr, tag_rd;
   logic            grant, rvalid_eff, buf_push, buf_pop;

   always_comb begin
      state_nxt  = state;
      occupancy  = {1'b0, inflight} + {1'b0, count};
      o_imem_req = 1'b0;
      case (state)
         IDLE:  state_nxt = FETCH;
         FETCH: begin
            state_nxt  = FETCH;
            o_imem_req = !i_redirect && (occupancy < DEPTH_W);
         end
      endcase
   end

   // Responses seen in the IDLE cycle belong to pre-reset requests and are ignored.
   assign grant      = o_imem_req & i_imem_gnt;
   assign rvalid_eff = i_imem_rvalid & (state == FETCH);
   assign buf_push   = rvalid_eff & (discard == '0) & !i_redirect;
   assign buf_pop    = o_valid & i_ready & !i_redirect;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         inflight <= '0;
         count    <= '0;
         discard  <= '0;
         buf_wr   <= '0;
         buf_rd   <= '0;
         tag_wr   <= '0;
         tag_rd   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            buf_pc[i]    <= RESET_PC;
            buf_instr[i] <= '0;
            tag_q[i]     <= '0;
         end
      end else begin
         state    <= state_nxt;
         inflight <= inflight + CW'(grant) - CW'(rvalid_eff);
         if (grant) begin
            tag_q[tag_wr] <= fetch_pc;
            tag_wr        <= tag_wr + 1'b1;
         end
         // Discarded responses still consume their tag so later tags stay aligned.
         if (rvalid_eff) tag_rd <= tag_rd + 1'b1;
         if (i_redirect) begin
            fetch_pc <= i_redirect_pc;
            count    <= '0;
            buf_rd   <= buf_wr;
            discard  <= inflight - CW'(rvalid_eff);
         end else begin
            if (grant) fetch_pc <= fetch_pc + XLEN'(4);
            if (rvalid_eff && (discard != '0)) discard <= discard - 1'b1;
            if (buf_push) begin
               buf_pc[buf_wr]    <= tag_q[tag_rd];
               buf_instr[buf_wr] <= i_imem_rdata;
               buf_wr            <= buf_wr + 1'b1;
            end
            if (buf_pop) buf_rd <= buf_rd + 1'b1;
            count <= count + CW'(buf_push) - CW'(buf_pop);
         end
      end
   end

   assign o_imem_addr = fetch_pc;
   assign o_valid     = (count != '0);
   assign o_pc        = buf_pc[buf_rd];
   assign o_inc_pc    = o_pc + XLEN'(4);
   assign o_instr     = buf_instr[buf_rd];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios push expected decode
// transfers; a negedge monitor pops and compares every accepted head.
module tb_if_fetch_unit;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n, redirect, gnt, rvalid, ready;
   logic [31:0] redirect_pc, rdata;
   logic        o_imem_req, o_valid;
   logic [31:0] o_imem_addr, o_pc, o_inc_pc, o_instr;

   always #5 clk = ~clk;

   if_fetch_unit #(.XLEN(32), .RESET_PC(32'h4), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(gnt),
      .i_imem_rvalid(rvalid), .i_imem_rdata(rdata), .o_valid(o_valid), .i_ready(ready),
      .o_pc(o_pc), .o_inc_pc(o_inc_pc), .o_instr(o_instr)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inc;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q[$];
   logic [31:0] pend_addr[$];
   int          pend_rem[$];
   logic [31:0] grant_log[$];
   logic [31:0] want[$];
   int          grants = 0;
   int          lat = 1;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'd7) ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] inc);
      exp_t e;
      e.pc = pc;
      e.inc = inc;
      exp_q.push_back(e);
   endtask

   // Monitor: the handshake visible at a negedge is the one taken at the next posedge.
   always @(negedge clk) begin
      if (rst_n && !redirect && o_valid && ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop actual_pc=%h required=none", o_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pop_pc", o_pc, e.pc);
            check("pop_inc_pc", o_inc_pc, e.inc);
            check("pop_instr", o_instr, mem(e.pc));
         end
      end
   end

   // One clock: record grants and invariants at negedge, then drive the cache reply.
   task automatic cycle();
      @(negedge clk);
      if (!rst_n) begin
         pend_addr.delete();
         pend_rem.delete();
      end else begin
         if (o_imem_req && gnt) begin
            pend_addr.push_back(o_imem_addr);
            pend_rem.push_back(lat);
            grant_log.push_back(o_imem_addr);
            grants++;
         end
         if (dut.rvalid_eff) check("rvalid_with_inflight", 32'(dut.inflight != '0), 32'd1);
         if (dut.buf_push) check("push_into_full", 32'(dut.count >= DEPTH), 32'd0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < pend_rem.size(); i++) pend_rem[i]--;
      if (pend_rem.size() > 0 && pend_rem[0] <= 0) begin
         rvalid = 1'b1;
         rdata  = mem(pend_addr.pop_front());
         void'(pend_rem.pop_front());
      end else begin
         rvalid = 1'b0;
         rdata  = '0;
      end
   endtask

   task automatic do_reset(input bit stale);
      rst_n = 1'b0; gnt = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      grant_log.delete();
      grants = 0;
      cycle();
      check("rst_req", o_imem_req, 1'b0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_addr", o_imem_addr, 32'h4);
      check("rst_pc", o_pc, 32'h4);
      check("rst_inc_pc", o_inc_pc, 32'h8);
      check("rst_instr", o_instr, 32'h0);
      rst_n = 1'b1;
      if (stale) begin
         rvalid = 1'b1;
         rdata  = 32'hBAD0_0BAD;
      end
      cycle();
   endtask

   task automatic run_grants(input int n);
      int k = 0;
      while (grants < n && k < 40) begin
         cycle();
         k++;
      end
      check("grant_count", grants, n);
      gnt = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || pend_addr.size() != 0 || o_valid) && n < 50) begin
         cycle();
         n++;
      end
      check({name, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic check_log(input string name);
      check({name, "_log_len"}, grant_log.size(), want.size());
      for (int i = 0; i < want.size(); i++)
         if (i < grant_log.size()) check({name, "_req_addr"}, grant_log[i], want[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; gnt = 1'b0; ready = 1'b0; redirect = 1'b0;
      redirect_pc = '0; rvalid = 1'b0; rdata = '0;

      // 1: streaming fetch
      do_reset(1'b0);
      lat = 1; gnt = 1'b1; ready = 1'b1;
      push_exp(32'h04, 32'h08); push_exp(32'h08, 32'h0C); push_exp(32'h0C, 32'h10);
      push_exp(32'h10, 32'h14); push_exp(32'h14, 32'h18); push_exp(32'h18, 32'h1C);
      run_grants(6);
      drain("t1");
      want = {32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
      check_log("t1");

      // 2: decode stalled, credits exhausted
      do_reset(1'b0);
      lat = 1; gnt = 1'b1; ready = 1'b0;
      repeat (6) cycle();
      want = {32'h04, 32'h08};
      check_log("t2_stall");
      check("t2_req_blocked", o_imem_req, 1'b0);
      check("t2_valid_held", o_valid, 1'b1);
      check("t2_pc_held", o_pc, 32'h4);
      push_exp(32'h04, 32'h08); push_exp(32'h08, 32'h0C); push_exp(32'h0C, 32'h10);
      ready = 1'b1;
      run_grants(3);
      drain("t2");
      want = {32'h04, 32'h08, 32'h0C};
      check_log("t2");

      // 3: grant withheld, address stable
      do_reset(1'b0);
      lat = 1; gnt = 1'b0; ready = 1'b1;
      repeat (3) begin
         cycle();
         check("t3_req", o_imem_req, 1'b1);
         check("t3_addr", o_imem_addr, 32'h4);
      end
      push_exp(32'h04, 32'h08);
      gnt = 1'b1;
      run_grants(1);
      drain("t3");
      want = {32'h04};
      check_log("t3");

      // 4: redirect while two requests are outstanding, first reply arriving now
      do_reset(1'b0);
      lat = 2; gnt = 1'b1; ready = 1'b0;
      run_grants(2);
      gnt = 1'b1;
      redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      check("t4_req_in_redirect", o_imem_req, 1'b0);
      cycle();
      redirect = 1'b0; ready = 1'b1;
      check("t4_addr", o_imem_addr, 32'h100);
      check("t4_valid_flushed", o_valid, 1'b0);
      push_exp(32'h100, 32'h104); push_exp(32'h104, 32'h108);
      run_grants(4);
      drain("t4");
      want = {32'h04, 32'h08, 32'h100, 32'h104};
      check_log("t4");

      // 5: back-to-back redirects, last wins; address wrap
      do_reset(1'b0);
      lat = 1; gnt = 1'b0; ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'h200;
      cycle();
      redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect = 1'b0;
      check("t5_addr", o_imem_addr, 32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC, 32'h0); push_exp(32'h0, 32'h4);
      gnt = 1'b1;
      run_grants(2);
      drain("t5");
      want = {32'hFFFF_FFFC, 32'h0};
      check_log("t5");

      // 6: reset with a full buffer and a stale reply in the IDLE cycle
      do_reset(1'b0);
      lat = 1; gnt = 1'b1; ready = 1'b0;
      run_grants(2);
      repeat (3) cycle();
      check("t6_full_valid", o_valid, 1'b1);
      check("t6_full_req", o_imem_req, 1'b0);
      do_reset(1'b1);
      check("t6_req_after", o_imem_req, 1'b1);
      check("t6_addr_after", o_imem_addr, 32'h4);
      check("t6_valid_after", o_valid, 1'b0);
      push_exp(32'h04, 32'h08); push_exp(32'h08, 32'h0C);
      lat = 1; gnt = 1'b1; ready = 1'b1;
      run_grants(2);
      drain("t6");
      want = {32'h04, 32'h08};
      check_log("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
